// File: rtl/out_pkt_fifo.sv
// USB full-speed OUT endpoint FIFO: stores whole packets, commits them at EOP, rolls back
// on abort or oversize, and NAKs a packet up front when a max-size packet or a slot won't fit.
module out_pkt_fifo #(
    parameter int unsigned OUT_MAXPACKETSIZE = 64,
    parameter int unsigned FIFO_DEPTH        = 128,
    parameter int unsigned PKT_SLOTS         = 4
) (
    input  logic                             clk_i,
    input  logic                             rstn_i,
    input  logic                             clk_gate_i,
    input  logic [7:0]                       out_data_i,
    input  logic                             out_valid_i,
    input  logic                             out_err_i,
    input  logic                             out_ready_i,
    output logic                             out_nak_o,
    output logic                             out_full_o,
    output logic                             out_empty_o,
    output logic [$clog2(PKT_SLOTS+1)-1:0]   pkt_count_o,
    output logic [7:0]                       app_out_data_o,
    output logic                             app_out_valid_o,
    output logic                             app_out_last_o,
    input  logic                             app_out_ready_i
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned LEN_W  = $clog2(OUT_MAXPACKETSIZE + 1);
    localparam int unsigned SLOT_W = (PKT_SLOTS > 1) ? $clog2(PKT_SLOTS) : 1;
    localparam int unsigned PCNT_W = $clog2(PKT_SLOTS + 1);

    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PKT_SLOTS - 1);
    localparam logic [CNT_W-1:0]  ROOM_MAX  = CNT_W'(FIFO_DEPTH - OUT_MAXPACKETSIZE);
    localparam logic [LEN_W-1:0]  MPS       = LEN_W'(OUT_MAXPACKETSIZE);
    localparam logic [PCNT_W-1:0] SLOTS     = PCNT_W'(PKT_SLOTS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_NAK
    } state_t;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [SLOT_W-1:0] slot_inc(input logic [SLOT_W-1:0] s);
        return (s == LAST_SLOT) ? '0 : s + SLOT_W'(1);
    endfunction

    logic [7:0]        mem     [FIFO_DEPTH];
    logic [LEN_W-1:0]  len_mem [PKT_SLOTS];

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d, cptr_q, rptr_q;
    logic [LEN_W-1:0]  wcnt_q, wcnt_d, rcnt_q;
    logic [CNT_W-1:0]  cbytes_q;
    logic [PCNT_W-1:0] pcnt_q;
    logic [SLOT_W-1:0] lwptr_q, lrptr_q;
    logic              mem_we, commit;

    // An abort wins over a byte if the SIE ever flags both in one strobe.
    logic sie_evt, is_byte, is_eop, is_err;
    assign sie_evt = clk_gate_i & out_ready_i;
    assign is_err  = sie_evt & out_err_i;
    assign is_byte = sie_evt & out_valid_i & ~out_err_i;
    assign is_eop  = sie_evt & ~out_valid_i & ~out_err_i;

    // Admission looks only at registered occupancy, so a same-cycle pop never rescues a packet.
    logic room_ok;
    assign room_ok = (cbytes_q <= ROOM_MAX) && (pcnt_q != SLOTS);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        wptr_d  = wptr_q;
        wcnt_d  = wcnt_q;
        mem_we  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_byte) begin
                    if (room_ok) begin
                        mem_we  = 1'b1;
                        wptr_d  = ptr_inc(wptr_q);
                        wcnt_d  = LEN_W'(1);
                        state_d = ST_RECV;
                    end else begin
                        state_d = ST_NAK;
                    end
                end
            end
            ST_RECV: begin
                if (is_byte) begin
                    if (wcnt_q < MPS) begin
                        mem_we = 1'b1;
                        wptr_d = ptr_inc(wptr_q);
                        wcnt_d = wcnt_q + LEN_W'(1);
                    end else begin
                        wptr_d  = cptr_q;
                        state_d = ST_NAK;
                    end
                end else if (is_eop) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end else if (is_err) begin
                    wptr_d  = cptr_q;
                    state_d = ST_IDLE;
                end
            end
            ST_NAK: begin
                if (is_eop || is_err) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    logic                 rd_load, rd_last, pop;
    logic [LEN_W-1:0]     head_len;
    assign head_len = len_mem[lrptr_q];
    assign rd_load  = (cbytes_q != '0) && (!app_out_valid_o || app_out_ready_i);
    assign rd_last  = ((LEN_W+1)'(rcnt_q) + (LEN_W+1)'(1)) == (LEN_W+1)'(head_len);
    assign pop      = rd_load & rd_last;

    // NOTE: storage arrays carry no reset; pointers and counters alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem[wptr_q] <= out_data_i;
        if (commit) len_mem[lwptr_q] <= wcnt_q;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q         <= ST_IDLE;
            wptr_q          <= '0;
            cptr_q          <= '0;
            wcnt_q          <= '0;
            rptr_q          <= '0;
            rcnt_q          <= '0;
            cbytes_q        <= '0;
            pcnt_q          <= '0;
            lwptr_q         <= '0;
            lrptr_q         <= '0;
            app_out_data_o  <= '0;
            app_out_valid_o <= 1'b0;
            app_out_last_o  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q <= state_d;
            wptr_q  <= wptr_d;
            wcnt_q  <= wcnt_d;
            if (commit) begin
                cptr_q  <= wptr_q;
                lwptr_q <= slot_inc(lwptr_q);
            end
            cbytes_q <= cbytes_q + (commit ? CNT_W'(wcnt_q) : '0) - CNT_W'(rd_load);
            pcnt_q   <= pcnt_q + PCNT_W'(commit) - PCNT_W'(pop);
            if (rd_load) begin
                app_out_data_o  <= mem[rptr_q];
                app_out_valid_o <= 1'b1;
                app_out_last_o  <= rd_last;
                rptr_q          <= ptr_inc(rptr_q);
                rcnt_q          <= rd_last ? '0 : rcnt_q + LEN_W'(1);
                if (rd_last) lrptr_q <= slot_inc(lrptr_q);
            end else if (app_out_ready_i) begin
                app_out_valid_o <= 1'b0;
                app_out_last_o  <= 1'b0;
            end
        end
    end

    assign out_nak_o   = (state_q == ST_NAK);
    assign out_full_o  = (cbytes_q > ROOM_MAX) || (pcnt_q == SLOTS);
    assign out_empty_o = (cbytes_q == '0) && !app_out_valid_o;
    assign pkt_count_o = pcnt_q;

endmodule

// File: tb/tb_out_pkt_fifo.sv
// Randomised bench for out_pkt_fifo: a packet-level model predicts delivered beats,
// NAK decisions and the status outputs from committed and consumed byte totals.
module tb_out_pkt_fifo;

    localparam int MPS   = 8;
    localparam int DEPTH = 20;
    localparam int SLOTS = 4;
    localparam int PCW   = $clog2(SLOTS + 1);
    localparam int EV_BYTE = 0, EV_EOP = 1, EV_ERR = 2;
    localparam int WS_IDLE = 0, WS_RECV = 1, WS_NAK = 2;

    logic           clk_i = 1'b0;
    logic           rstn_i;
    logic           clk_gate_i, out_valid_i, out_err_i, out_ready_i;
    logic [7:0]     out_data_i;
    logic           out_nak_o, out_full_o, out_empty_o;
    logic [PCW-1:0] pkt_count_o;
    logic [7:0]     app_out_data_o;
    logic           app_out_valid_o, app_out_last_o, app_out_ready_i;

    always #5 clk_i = ~clk_i;

    out_pkt_fifo #(
        .OUT_MAXPACKETSIZE (MPS),
        .FIFO_DEPTH        (DEPTH),
        .PKT_SLOTS         (SLOTS)
    ) dut (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .clk_gate_i      (clk_gate_i),
        .out_data_i      (out_data_i),
        .out_valid_i     (out_valid_i),
        .out_err_i       (out_err_i),
        .out_ready_i     (out_ready_i),
        .out_nak_o       (out_nak_o),
        .out_full_o      (out_full_o),
        .out_empty_o     (out_empty_o),
        .pkt_count_o     (pkt_count_o),
        .app_out_data_o  (app_out_data_o),
        .app_out_valid_o (app_out_valid_o),
        .app_out_last_o  (app_out_last_o),
        .app_out_ready_i (app_out_ready_i)
    );

    int n_cmp = 0, n_bad = 0;

    // Model: committed bytes in delivery order, cumulative packet end offsets, and totals.
    logic [7:0] exp_q[$];
    bit         last_q[$];
    int         pkt_end_q[$];
    logic [7:0] cur_q[$];
    int         ws = WS_IDLE;
    int         tot_c = 0;
    int         hs = 0;
    int         ready_mode = 0;

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Once settled, the output register holds a byte exactly when something is unconsumed.
    function automatic int loaded_bytes();
        return hs + ((tot_c > hs) ? 1 : 0);
    endfunction

    function automatic int model_pkt_count();
        int l = loaded_bytes();
        int n = 0;
        foreach (pkt_end_q[i]) if (pkt_end_q[i] > l) n++;
        return n;
    endfunction

    function automatic int model_free();
        return DEPTH - (tot_c - loaded_bytes());
    endfunction

    task automatic check_status();
        int pc = model_pkt_count();
        int fr = model_free();
        check("nak", out_nak_o, int'(ws == WS_NAK));
        check("pkt_count", pkt_count_o, pc);
        check("full", out_full_o, int'((fr < MPS) || (pc >= SLOTS)));
        check("empty", out_empty_o, int'(tot_c == hs));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_nak"}, out_nak_o, 0);
        check({tag, "_full"}, out_full_o, 0);
        check({tag, "_empty"}, out_empty_o, 1);
        check({tag, "_pkt_count"}, pkt_count_o, 0);
        check({tag, "_valid"}, app_out_valid_o, 0);
        check({tag, "_last"}, app_out_last_o, 0);
        check({tag, "_data"}, app_out_data_o, 0);
    endtask

    task automatic quiet();
        clk_gate_i  = 1'b0;
        out_ready_i = 1'b0;
        out_valid_i = 1'b0;
        out_err_i   = 1'b0;
        out_data_i  = 8'h00;
    endtask

    // Idle SIE cycles with random junk that must never form an event (gate and strobe never both high).
    task automatic noise_cycles(input int n);
        repeat (n) begin
            clk_gate_i  = 1'($urandom_range(0, 1));
            out_ready_i = clk_gate_i ? 1'b0 : 1'($urandom_range(0, 1));
            out_valid_i = 1'($urandom_range(0, 1));
            out_err_i   = 1'($urandom_range(0, 1));
            out_data_i  = 8'($urandom);
            @(posedge clk_i); #1;
        end
        quiet();
    endtask

    task automatic sie(input int kind, input logic [7:0] b);
        check_status();
        case (ws)
            WS_IDLE: if (kind == EV_BYTE) begin
                if (model_free() >= MPS && model_pkt_count() < SLOTS) begin
                    cur_q.delete();
                    cur_q.push_back(b);
                    ws = WS_RECV;
                end else begin
                    ws = WS_NAK;
                end
            end
            WS_RECV: begin
                if (kind == EV_BYTE) begin
                    if (cur_q.size() < MPS) cur_q.push_back(b);
                    else begin cur_q.delete(); ws = WS_NAK; end
                end else if (kind == EV_EOP) begin
                    foreach (cur_q[i]) begin
                        exp_q.push_back(cur_q[i]);
                        last_q.push_back(i == cur_q.size() - 1);
                    end
                    tot_c += cur_q.size();
                    pkt_end_q.push_back(tot_c);
                    cur_q.delete();
                    ws = WS_IDLE;
                end else begin
                    cur_q.delete();
                    ws = WS_IDLE;
                end
            end
            default: if (kind != EV_BYTE) ws = WS_IDLE;
        endcase
        clk_gate_i  = 1'b1;
        out_ready_i = 1'b1;
        out_valid_i = (kind == EV_BYTE);
        out_err_i   = (kind == EV_ERR);
        out_data_i  = b;
        @(posedge clk_i); #1;
        quiet();
        check("nak_after_event", out_nak_o, int'(ws == WS_NAK));
        noise_cycles(3);
    endtask

    task automatic send_pkt(input int n, input int ending);
        for (int i = 0; i < n; i++) sie(EV_BYTE, 8'($urandom));
        sie(ending, 8'h00);
    endtask

    task automatic drain();
        int budget = 0;
        ready_mode = 1;
        while (hs != tot_c && budget < 2000) begin
            @(posedge clk_i); #1;
            budget++;
        end
        check("drain_done", hs, tot_c);
        noise_cycles(3);
        check_status();
        while (pkt_end_q.size() > 0 && pkt_end_q[0] <= hs) void'(pkt_end_q.pop_front());
    endtask

    // Application side: choose ready at the falling edge, then score the beat taken at the next rising edge.
    initial begin
        app_out_ready_i = 1'b0;
        forever begin
            @(negedge clk_i);
            case (ready_mode)
                0: app_out_ready_i = 1'b0;
                1: app_out_ready_i = 1'b1;
                2: app_out_ready_i = ($urandom_range(0, 2) != 0);
                default: app_out_ready_i = ($urandom_range(0, 3) == 0);
            endcase
            if (rstn_i && app_out_valid_o && app_out_ready_i) begin
                check("beat_pending", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    check("beat_data", app_out_data_o, int'(exp_q.pop_front()));
                    check("beat_last", app_out_last_o, int'(last_q.pop_front()));
                end
                hs++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        quiet();
        rstn_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_outputs("reset");
        rstn_i = 1'b1;
        @(posedge clk_i); #1;

        // Three bytes delivered in order, last only on the final one.
        ready_mode = 1;
        sie(EV_BYTE, 8'h11); sie(EV_BYTE, 8'h22); sie(EV_BYTE, 8'h33); sie(EV_EOP, 8'h00);
        drain();
        check("t1_empty", out_empty_o, 1);

        // Aborted packet leaves no trace; the following one-byte packet is delivered.
        sie(EV_BYTE, 8'hAA); sie(EV_BYTE, 8'hBB); sie(EV_ERR, 8'h00);
        sie(EV_BYTE, 8'h01); sie(EV_EOP, 8'h00);
        drain();

        // Fill every slot with the application stalled, then a NAKed packet.
        ready_mode = 0;
        for (int p = 0; p < SLOTS; p++) send_pkt(2, EV_EOP);
        check("t3_pkt_count", pkt_count_o, SLOTS);
        check("t3_full", out_full_o, 1);
        sie(EV_BYTE, 8'h5A);
        check("t3_nak_first", out_nak_o, 1);
        sie(EV_BYTE, 8'h5B);
        sie(EV_EOP, 8'h00);
        check("t3_nak_clear", out_nak_o, 0);
        drain();

        // Oversize packet is rolled back; a full max-size packet then fits.
        for (int i = 0; i < MPS; i++) sie(EV_BYTE, 8'(8'hC0 + i));
        check("t4_nak_before", out_nak_o, 0);
        sie(EV_BYTE, 8'hC8);
        check("t4_nak_oversize", out_nak_o, 1);
        sie(EV_EOP, 8'h00);
        drain();
        check("t4_empty", out_empty_o, 1);
        sie(EV_BYTE, 8'hD0);
        check("t4_accept", out_nak_o, 0);
        for (int i = 1; i < MPS; i++) sie(EV_BYTE, 8'(8'hD0 + i));
        sie(EV_EOP, 8'h00);
        drain();

        // Ten 7-byte packets wrap the pointers several times.
        for (int p = 0; p < 10; p++) send_pkt(7, EV_EOP);
        drain();

        // Zero-length packet and reset in the middle of a packet.
        sie(EV_EOP, 8'h00);
        check("t6_pkt_count", pkt_count_o, 0);
        check("t6_empty", out_empty_o, 1);
        sie(EV_BYTE, 8'h77); sie(EV_BYTE, 8'h78);
        rstn_i = 1'b0;
        #1;
        check_reset_outputs("midreset");
        ws = WS_IDLE;
        cur_q.delete();
        exp_q.delete();
        last_q.delete();
        pkt_end_q.delete();
        hs = tot_c;
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        @(posedge clk_i); #1;
        check_reset_outputs("after_reset");
        sie(EV_BYTE, 8'h90); sie(EV_BYTE, 8'h91); sie(EV_BYTE, 8'h92); sie(EV_EOP, 8'h00);
        drain();

        // Random traffic against a slow or bursty application.
        for (int p = 0; p < 40; p++) begin
            ready_mode = (p < 20) ? 3 : 2;
            send_pkt($urandom_range(0, MPS + 2), ($urandom_range(0, 9) == 0) ? EV_ERR : EV_EOP);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
